// File: rtl/ks_pipe_adder_pkg.sv
// Shared constants and elaboration helpers for the pipelined Kogge-Stone adder.
package ks_pipe_adder_pkg;

    // Bits resolved per pipeline stage; fixed by the ksadder_16 slice.
    localparam int unsigned SLICE = 16;

    // Legal operand widths are whole, non-zero multiples of the slice width.
    function automatic bit width_ok(int unsigned width);
        return (width >= SLICE) && ((width % SLICE) == 0);
    endfunction

endpackage

// File: rtl/ksadder_16.sv
// 16-bit Kogge-Stone adder slice with carry-in and carry-out.
module ksadder_16 (
    input  logic [15:0] a_n,
    input  logic [15:0] b_n,
    input  logic        cin,
    output logic [15:0] s_n,
    output logic        cout
);

    logic [4:0][15:0] g_lvl;
    logic [4:0][15:0] p_lvl;
    logic [16:0]      carry;

    // Log-depth parallel prefix over (generate, propagate) pairs.
    always_comb begin
        g_lvl[0] = a_n & b_n;
        p_lvl[0] = a_n ^ b_n;
        for (int l = 0; l < 4; l++) begin
            g_lvl[l+1] = g_lvl[l];
            p_lvl[l+1] = p_lvl[l];
            for (int i = (1 << l); i < 16; i++) begin
                g_lvl[l+1][i] = g_lvl[l][i] | (p_lvl[l][i] & g_lvl[l][i-(1<<l)]);
                p_lvl[l+1][i] = p_lvl[l][i] & p_lvl[l][i-(1<<l)];
            end
        end
    end

    // Fold carry-in through the group propagate, then form sum bits.
    always_comb begin
        carry = {g_lvl[4] | (p_lvl[4] & {16{cin}}), cin};
        s_n   = p_lvl[0] ^ carry[15:0];
        cout  = carry[16];
    end

endmodule

// File: rtl/ks_pipe_adder.sv
// Elastic pipelined wide adder: one 16-bit Kogge-Stone slice resolved per stage,
// carry and not-yet-added operand slices carried forward in registers.
module ks_pipe_adder
    import ks_pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned STAGES = WIDTH / SLICE;

    if (!width_ok(WIDTH)) begin : gen_width_check
        $error("ks_pipe_adder: WIDTH must be a non-zero multiple of 16");
    end

    logic [STAGES:0]              ready;
    logic [STAGES-1:0]            stage_valid;
    logic [STAGES-1:0]            stage_carry;
    logic [STAGES-1:0][WIDTH-1:0] stage_sum;
    // Skew registers hold remaining operand slices shifted down, next slice in [15:0].
    logic [STAGES-1:0][WIDTH-1:0] stage_a;
    logic [STAGES-1:0][WIDTH-1:0] stage_b;

    // Ready ripples back from the consumer; an empty stage is always ready.
    always_comb begin
        ready         = '0;
        ready[STAGES] = out_ready;
        for (int s = STAGES; s > 0; s--) begin
            ready[s-1] = ~stage_valid[s-1] | ready[s];
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : gen_stage
        logic [SLICE-1:0] op_a;
        logic [SLICE-1:0] op_b;
        logic             op_c;
        logic             valid_in;
        logic [WIDTH-1:0] sum_base;
        logic [WIDTH-1:0] a_rest;
        logic [WIDTH-1:0] b_rest;
        logic [SLICE-1:0] slice_sum;
        logic             slice_cout;
        logic [WIDTH-1:0] sum_next;
        logic             valid_q;
        logic             carry_q;
        logic [WIDTH-1:0] sum_q;
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;

        if (s == 0) begin : gen_first
            // First stage takes its slice straight from the input operands.
            always_comb begin
                op_a     = a[SLICE-1:0];
                op_b     = b[SLICE-1:0];
                op_c     = cin;
                valid_in = in_valid;
                sum_base = '0;
                a_rest   = a >> SLICE;
                b_rest   = b >> SLICE;
            end
        end else begin : gen_next
            // Later stages consume the next skewed slice and the previous carry.
            always_comb begin
                op_a     = stage_a[s-1][SLICE-1:0];
                op_b     = stage_b[s-1][SLICE-1:0];
                op_c     = stage_carry[s-1];
                valid_in = stage_valid[s-1];
                sum_base = stage_sum[s-1];
                a_rest   = stage_a[s-1] >> SLICE;
                b_rest   = stage_b[s-1] >> SLICE;
            end
        end

        ksadder_16 u_add (
            .a_n  (op_a),
            .b_n  (op_b),
            .cin  (op_c),
            .s_n  (slice_sum),
            .cout (slice_cout)
        );

        // Append this stage's sum slice to the partial sum.
        always_comb begin
            sum_next                   = sum_base;
            sum_next[s*SLICE +: SLICE] = slice_sum;
        end

        // Stage register: load whenever ready, otherwise hold.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
                a_q     <= '0;
                b_q     <= '0;
            end else if (ready[s]) begin
                valid_q <= valid_in;
                carry_q <= slice_cout;
                sum_q   <= sum_next;
                a_q     <= a_rest;
                b_q     <= b_rest;
            end
        end

        assign stage_valid[s] = valid_q;
        assign stage_carry[s] = carry_q;
        assign stage_sum[s]   = sum_q;
        assign stage_a[s]     = a_q;
        assign stage_b[s]     = b_q;
    end

    // The last stage has no operand slices left to pass on.
    logic unused_skew;
    assign unused_skew = ^{stage_a[STAGES-1], stage_b[STAGES-1]};

    assign in_ready  = ready[0];
    assign out_valid = stage_valid[STAGES-1];
    assign sum       = stage_sum[STAGES-1];
    assign cout      = stage_carry[STAGES-1];

endmodule
